// File: rtl/bsg_manycore_pkt_decode_rx.sv
// Receive side of the manycore remote-store path: buffers packets, checks the destination,
// decodes op/op_ex into a local store request and returns one credit per retired packet.
// Optional BSG_MANYCORE_PKT_DECODE_STATS_EN adds saturating store/drop counters.
module bsg_manycore_pkt_decode_rx #(
  parameter int x_cord_width_p  = 4,
  parameter int y_cord_width_p  = 4,
  parameter int data_width_p    = 32,
  parameter int addr_width_p    = 12,
  parameter int fifo_els_p      = 2,
  parameter int packet_width_lp = addr_width_p + 2 + (data_width_p / 8) + data_width_p
                                  + x_cord_width_p + y_cord_width_p
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic [x_cord_width_p-1:0]   my_x_i,
  input  logic [y_cord_width_p-1:0]   my_y_i,
  input  logic                        v_i,
  input  logic [packet_width_lp-1:0]  data_i,
  output logic                        ready_o,
  output logic                        v_o,
  output logic [addr_width_p:0]       addr_o,
  output logic [data_width_p-1:0]     data_o,
  output logic [data_width_p/8-1:0]   mask_o,
  input  logic                        yumi_i,
  output logic                        credit_o,
`ifdef BSG_MANYCORE_PKT_DECODE_STATS_EN
  output logic [31:0]                 stat_stores_o,
  output logic [15:0]                 stat_drops_o,
`endif
  output logic                        err_o
);

  localparam int mask_width_lp = data_width_p / 8;
  localparam int ptr_width_lp  = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
  localparam int cnt_width_lp  = $clog2(fifo_els_p + 1);

  // Packet layout, LSB first: y_cord, x_cord, data, op_ex, op, addr
  localparam int x_lsb_lp    = y_cord_width_p;
  localparam int data_lsb_lp = x_lsb_lp + x_cord_width_p;
  localparam int opex_lsb_lp = data_lsb_lp + data_width_p;
  localparam int op_lsb_lp   = opex_lsb_lp + mask_width_lp;
  localparam int addr_lsb_lp = op_lsb_lp + 2;

  typedef enum logic {IDLE, VALID} state_e;

  state_e state_r, state_n;

  logic [packet_width_lp-1:0] fifo_mem [fifo_els_p];
  logic [ptr_width_lp-1:0]    rd_ptr, wr_ptr;
  logic [cnt_width_lp-1:0]    count, count_next;
  logic                       fifo_empty;
  logic                       enq, pop, load, drop, consume;

  logic [packet_width_lp-1:0] head;
  logic [y_cord_width_p-1:0]  head_y;
  logic [x_cord_width_p-1:0]  head_x;
  logic [data_width_p-1:0]    head_data;
  logic [mask_width_lp-1:0]   head_op_ex;
  logic [1:0]                 head_op;
  logic [addr_width_p-1:0]    head_addr;
  logic                       head_good;
  logic                       head_ready;

  function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
    return (p == ptr_width_lp'(fifo_els_p - 1)) ? '0 : p + ptr_width_lp'(1);
  endfunction

  assign enq        = v_i & ready_o;
  assign fifo_empty = (count == '0);

  always_ff @(posedge clk_i) begin
    if (enq) fifo_mem[wr_ptr] <= data_i;
  end

  always_comb begin
    count_next = count;
    if (enq && !pop)      count_next = count + cnt_width_lp'(1);
    else if (!enq && pop) count_next = count - cnt_width_lp'(1);
  end

  // ready_o is registered from the next count so it never depends on this cycle's pop
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      ready_o <= 1'b1;
    end else begin
      if (enq) wr_ptr <= ptr_inc(wr_ptr);
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      count   <= count_next;
      ready_o <= (count_next != cnt_width_lp'(fifo_els_p));
    end
  end

  assign head       = fifo_mem[rd_ptr];
  assign head_y     = head[0 +: y_cord_width_p];
  assign head_x     = head[x_lsb_lp +: x_cord_width_p];
  assign head_data  = head[data_lsb_lp +: data_width_p];
  assign head_op_ex = head[opex_lsb_lp +: mask_width_lp];
  assign head_op    = head[op_lsb_lp +: 2];
  assign head_addr  = head[addr_lsb_lp +: addr_width_p];
  assign head_good  = ((head_op == 2'b01) || (head_op == 2'b10))
                      && (head_x == my_x_i) && (head_y == my_y_i);
  assign head_ready = !fifo_empty && head_good;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_r <= IDLE;
    else            state_r <= state_n;
  end

  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE:    if (head_ready) state_n = VALID;
      VALID:   if (yumi_i && !head_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // A bad head seen while VALID waits for IDLE so a drop never coincides with a consume
  always_comb begin
    load    = 1'b0;
    pop     = 1'b0;
    drop    = 1'b0;
    consume = 1'b0;
    v_o     = (state_r == VALID);
    case (state_r)
      IDLE: begin
        if (!fifo_empty) begin
          pop  = 1'b1;
          load = head_good;
          drop = !head_good;
        end
      end
      VALID: begin
        if (yumi_i) begin
          consume = 1'b1;
          load    = head_ready;
          pop     = head_ready;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      addr_o   <= '0;
      data_o   <= '0;
      mask_o   <= '0;
      credit_o <= 1'b0;
      err_o    <= 1'b0;
    end else begin
      if (load) begin
        addr_o <= {head_op == 2'b10, head_addr};
        data_o <= head_data;
        mask_o <= head_op_ex;
      end
      credit_o <= consume | drop;
      err_o    <= err_o | drop;
    end
  end

`ifdef BSG_MANYCORE_PKT_DECODE_STATS_EN
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      stat_stores_o <= '0;
      stat_drops_o  <= '0;
    end else begin
      if (consume && (stat_stores_o != '1)) stat_stores_o <= stat_stores_o + 32'd1;
      if (drop && (stat_drops_o != '1))     stat_drops_o  <= stat_drops_o + 16'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o);
`endif

endmodule

// File: tb/tb_bsg_manycore_pkt_decode_rx.sv
// Self-checking bench for bsg_manycore_pkt_decode_rx: queue-based reference model compared
// every cycle, plus directed literal checks for latency, op decode, drops and reset.
module tb_bsg_manycore_pkt_decode_rx;

  localparam int XW = 4;
  localparam int YW = 4;
  localparam int DW = 32;
  localparam int AW = 12;
  localparam int MW = DW / 8;
  localparam int N  = 2;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [1:0]    op;
    logic [MW-1:0] op_ex;
    logic [DW-1:0] data;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
  } pkt_t;

  localparam int PW = $bits(pkt_t);

  logic          clk;
  logic          reset_n;
  logic [XW-1:0] my_x;
  logic [YW-1:0] my_y;
  logic          v_i;
  logic [PW-1:0] data_i;
  logic          ready_o;
  logic          v_o;
  logic [AW:0]   addr_o;
  logic [DW-1:0] data_o;
  logic [MW-1:0] mask_o;
  logic          yumi_i;
  logic          credit_o;
  logic          err_o;
`ifdef BSG_MANYCORE_PKT_DECODE_STATS_EN
  logic [31:0]   stat_stores_o;
  logic [15:0]   stat_drops_o;
`endif

  int total = 0;
  int bad   = 0;
  int yumi_mode = 0;

  bsg_manycore_pkt_decode_rx #(
    .x_cord_width_p(XW),
    .y_cord_width_p(YW),
    .data_width_p  (DW),
    .addr_width_p  (AW),
    .fifo_els_p    (N)
  ) dut (
    .clk_i    (clk),
    .reset_n_i(reset_n),
    .my_x_i   (my_x),
    .my_y_i   (my_y),
    .v_i      (v_i),
    .data_i   (data_i),
    .ready_o  (ready_o),
    .v_o      (v_o),
    .addr_o   (addr_o),
    .data_o   (data_o),
    .mask_o   (mask_o),
    .yumi_i   (yumi_i),
    .credit_o (credit_o),
`ifdef BSG_MANYCORE_PKT_DECODE_STATS_EN
    .stat_stores_o(stat_stores_o),
    .stat_drops_o (stat_drops_o),
`endif
    .err_o    (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a queue for the buffer and one slot for the presented request
  pkt_t mq[$];
  bit   m_valid = 0;
  pkt_t m_out;
  bit   m_credit = 0;
  bit   m_err = 0;
  bit   m_accepted = 0;
  int   m_stores = 0;
  int   m_drops = 0;

  function automatic bit is_good(input pkt_t p);
    return ((p.op == 2'b01) || (p.op == 2'b10)) && (p.x == my_x) && (p.y == my_y);
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      m_valid = 0; m_credit = 0; m_err = 0; m_accepted = 0;
      m_stores = 0; m_drops = 0;
    end else begin
      bit   can_take;
      pkt_t p;
      can_take = (mq.size() < N);
      m_credit = 0;
      if (m_valid) begin
        if (yumi_i) begin
          m_credit = 1;
          m_stores++;
          if (mq.size() > 0 && is_good(mq[0])) m_out = mq.pop_front();
          else m_valid = 0;
        end
      end else if (mq.size() > 0) begin
        p = mq.pop_front();
        if (is_good(p)) begin
          m_out = p;
          m_valid = 1;
        end else begin
          m_credit = 1;
          m_err = 1;
          m_drops++;
        end
      end
      m_accepted = v_i && can_take;
      if (m_accepted) mq.push_back(pkt_t'(data_i));
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("ready_o", ready_o, mq.size() < N);
    checkOutput("v_o", v_o, m_valid);
    checkOutput("credit_o", credit_o, m_credit);
    checkOutput("err_o", err_o, m_err);
    if (m_valid) begin
      checkOutput("addr_o", addr_o, {m_out.op == 2'b10, m_out.addr});
      checkOutput("data_o", data_o, m_out.data);
      checkOutput("mask_o", mask_o, m_out.op_ex);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    case (yumi_mode)
      1:       yumi_i = m_valid;
      2:       yumi_i = m_valid & ($urandom_range(0, 1) == 1);
      default: yumi_i = 1'b0;
    endcase
  endtask

  task automatic applyStimulus(input bit v, input pkt_t p, input bit y);
    v_i    = v;
    data_i = p;
    yumi_i = y;
  endtask

  function automatic pkt_t mkPkt(input logic [AW-1:0] a, input logic [1:0] op,
                                 input logic [MW-1:0] ex, input logic [DW-1:0] d,
                                 input logic [XW-1:0] x, input logic [YW-1:0] y);
    pkt_t p;
    p.addr = a; p.op = op; p.op_ex = ex; p.data = d; p.x = x; p.y = y;
    return p;
  endfunction

  function automatic pkt_t randPkt();
    pkt_t p;
    int   r;
    r = $urandom_range(0, 9);
    p.op    = (r < 4) ? 2'b10 : (r < 8) ? 2'b01 : (r == 8) ? 2'b00 : 2'b11;
    p.addr  = AW'($urandom);
    p.op_ex = MW'($urandom);
    p.data  = DW'($urandom);
    p.x     = ($urandom_range(0, 9) == 0) ? 4'd3 : my_x;
    p.y     = ($urandom_range(0, 9) == 0) ? 4'd7 : my_y;
    return p;
  endfunction

  // One isolated packet through an empty pipeline, with literal latency/decode checks
  task automatic sendDirected(input string tag, input pkt_t p, input bit good,
                              input logic [AW:0] exp_addr, input logic [MW-1:0] exp_mask);
    applyStimulus(1, p, 0);
    tick();
    applyStimulus(0, p, 0);
    checkOutput({tag, "_n1_v"}, v_o, 0);
    tick();
    if (good) begin
      checkOutput({tag, "_n2_v"}, v_o, 1);
      checkOutput({tag, "_addr"}, addr_o, exp_addr);
      checkOutput({tag, "_data"}, data_o, p.data);
      checkOutput({tag, "_mask"}, mask_o, exp_mask);
      yumi_i = 1'b1;
      tick();
      checkOutput({tag, "_credit"}, credit_o, 1);
      checkOutput({tag, "_v_after"}, v_o, 0);
    end else begin
      checkOutput({tag, "_n2_v"}, v_o, 0);
      checkOutput({tag, "_credit"}, credit_o, 1);
      checkOutput({tag, "_err"}, err_o, 1);
    end
    tick();
    checkOutput({tag, "_credit_end"}, credit_o, 0);
  endtask

  task automatic pushPkt(input pkt_t p);
    v_i    = 1'b1;
    data_i = p;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (m_accepted) break;
    end
    if (!m_accepted) checkOutput("push_timeout", 0, 1);
    v_i = 1'b0;
  endtask

  initial begin
    pkt_t p, p1;
    int   credits;
    reset_n = 1'b1;
    my_x = 4'd1;
    my_y = 4'd2;
    applyStimulus(0, '0, 0);
    #1 reset_n = 1'b0;
    repeat (3) tick();
    checkOutput("rst_ready", ready_o, 1);
    checkOutput("rst_v", v_o, 0);
    checkOutput("rst_credit", credit_o, 0);
    checkOutput("rst_err", err_o, 0);
    checkOutput("rst_addr", addr_o, 0);
    checkOutput("rst_data", data_o, 0);
    reset_n = 1'b1;
    repeat (3) tick();
    checkOutput("idle_v", v_o, 0);

    $display("[TB] directed decode");
    sendDirected("good10", mkPkt(12'h005, 2'b10, 4'b0011, 32'hDEADBEEF, 4'd1, 4'd2), 1, 13'h1005, 4'b0011);
    checkOutput("good10_err", err_o, 0);
    sendDirected("good01", mkPkt(12'h005, 2'b01, 4'b0011, 32'hDEADBEEF, 4'd1, 4'd2), 1, 13'h0005, 4'b0011);
    sendDirected("badop00", mkPkt(12'h005, 2'b00, 4'b0011, 32'hDEADBEEF, 4'd1, 4'd2), 0, '0, '0);
    sendDirected("badop11", mkPkt(12'h005, 2'b11, 4'b0011, 32'hDEADBEEF, 4'd1, 4'd2), 0, '0, '0);
    sendDirected("wrongx", mkPkt(12'h0A0, 2'b10, 4'b1111, 32'h12345678, 4'd3, 4'd2), 0, '0, '0);
    sendDirected("after_drop", mkPkt(12'hFFF, 2'b10, 4'b1000, 32'hCAFEF00D, 4'd1, 4'd2), 1, 13'h1FFF, 4'b1000);
    checkOutput("err_sticky", err_o, 1);

    $display("[TB] backpressure");
    yumi_mode = 0;
    p1 = mkPkt(12'h010, 2'b10, 4'b0001, 32'h11111111, 4'd1, 4'd2);
    pushPkt(p1);
    pushPkt(mkPkt(12'h020, 2'b01, 4'b0010, 32'h22222222, 4'd1, 4'd2));
    pushPkt(mkPkt(12'h030, 2'b10, 4'b0100, 32'h33333333, 4'd1, 4'd2));
    applyStimulus(1, mkPkt(12'h040, 2'b01, 4'b1000, 32'h44444444, 4'd1, 4'd2), 0);
    repeat (10) tick();
    checkOutput("bp_ready_low", ready_o, 0);
    checkOutput("bp_v_held", v_o, 1);
    checkOutput("bp_addr_held", addr_o, 13'h1010);
    yumi_mode = 1;
    yumi_i = m_valid;
    credits = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (m_accepted) v_i = 1'b0;
      if (credit_o) credits++;
    end
    v_i = 1'b0;
    checkOutput("bp_credits", credits, 4);
    checkOutput("bp_drained", v_o, 0);

    $display("[TB] random traffic");
    yumi_mode = 2;
    for (int c = 0; c < 400; c++) begin
      v_i    = ($urandom_range(0, 2) != 0);
      data_i = randPkt();
      tick();
    end
    v_i = 1'b0;
    yumi_mode = 1;
    repeat (12) tick();

    $display("[TB] async reset with full buffer");
    yumi_mode = 0;
    for (int c = 0; c < 6; c++) begin
      p = randPkt();
      p.op = 2'b10; p.x = my_x; p.y = my_y;
      v_i = 1'b1;
      data_i = p;
      tick();
    end
    v_i = 1'b0;
    checkOutput("full_ready", ready_o, 0);
    checkOutput("full_v", v_o, 1);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("arst_ready", ready_o, 1);
    checkOutput("arst_v", v_o, 0);
    checkOutput("arst_credit", credit_o, 0);
    checkOutput("arst_err", err_o, 0);
    checkOutput("arst_addr", addr_o, 0);
    checkOutput("arst_mask", mask_o, 0);
    repeat (2) tick();
    reset_n = 1'b1;
    credits = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (credit_o) credits++;
    end
    checkOutput("arst_no_credits", credits, 0);

`ifdef BSG_MANYCORE_PKT_DECODE_STATS_EN
    checkOutput("stat_stores", stat_stores_o, m_stores);
    checkOutput("stat_drops", stat_drops_o, m_drops);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
